sel_arbiter: RTL



---
 rtl/sel_arb_pkg.sv | 15 +
 rtl/sel_arbiter_rr_pick.sv | 25 ++
 rtl/sel_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sel_arb_pkg.sv
// Shared types and helpers for the sel_arbiter round-robin arbiter.
package sel_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot2(input logic [1:0] idx);
        onehot2 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sel_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req starting at ptr, wrapping mod 4.
module rr_pick
    import sel_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx
);

    logic [1:0] pos_s;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        any   = 1'b0;
        idx   = ptr;
        pos_s = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos_s = ptr + 2'(k);
            any   = any | req[pos_s];
            idx   = req[pos_s] ? pos_s : idx;
        end
    end

endmodule

// File: rtl/sel_arbiter.sv
// Round-robin arbiter sharing the 4:1 select path with a bounded hold time.
// Optional per-requester grant counters: define SEL_ARBITER_GRANT_CNT_EN.
module sel_arbiter
    import sel_arb_pkg::*;
#(
    parameter int DW       = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data,
    output logic [N_REQ-1:0]    grant,
    output logic [1:0]          sel,
    output logic [DW-1:0]       out_data,
    output logic                out_valid,
`ifdef SEL_ARBITER_GRANT_CNT_EN
    output logic [N_REQ*8-1:0]  gnt_cnt,
`endif
    output logic                busy
);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] others_s, pick_req_s;
    logic [1:0]       pick_ptr_s, pick_idx_s;
    logic             pick_any_s, hold_last_s, release_s, new_grant_s;

    rr_pick u_rr_pick (
        .req (pick_req_s),
        .ptr (pick_ptr_s),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Arbitration inputs: IDLE searches all requests, a release searches only competitors.
    always_comb begin
        others_s    = req & ~onehot2(sel_q);
        hold_last_s = (hold_cnt_q == 4'(MAX_HOLD - 1));
        release_s   = ~req[sel_q] | (hold_last_s & (|others_s));
        if (state_q == IDLE) begin
            pick_req_s = req;
            pick_ptr_s = rr_ptr_q;
        end else begin
            pick_req_s = others_s;
            pick_ptr_s = sel_q + 2'd1;
        end
    end

    // Next-state and grant decision.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        new_grant_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d     = GRANT;
                    grant_d     = onehot2(pick_idx_s);
                    sel_d       = pick_idx_s;
                    hold_cnt_d  = 4'd0;
                    new_grant_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    rr_ptr_d = sel_q + 2'd1;
                    if (pick_any_s) begin
                        grant_d     = onehot2(pick_idx_s);
                        sel_d       = pick_idx_s;
                        hold_cnt_d  = 4'd0;
                        new_grant_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end else if (hold_last_s) begin
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
        busy_d = (state_d == GRANT);
    end

    // Output stage trails the grant by one cycle and holds data while not valid.
    always_comb begin
        out_valid_d = (state_q == GRANT) && req[sel_q];
        if (out_valid_d) begin
            out_data_d = data[sel_q*DW +: DW];
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            grant_q     <= 4'b0000;
            sel_q       <= 2'd0;
            rr_ptr_q    <= 2'd0;
            hold_cnt_q  <= 4'd0;
            out_data_q  <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SEL_ARBITER_GRANT_CNT_EN
    logic [7:0] cnt_q [N_REQ];
    logic [7:0] cnt_d [N_REQ];

    // Saturating count of grants issued to each requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            if (new_grant_s && (pick_idx_s == 2'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt_out
        assign gnt_cnt[gi*8 +: 8] = cnt_q[gi];
    end
`endif

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
